// File: rtl/ctrl_link_pkg.sv
// Shared definitions for the analog-controls serial link (ctrl_tx / a_ctrls).
// Sync byte, channel index names, FSM state types and baud divider helper.
package ctrl_link_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      CH_A8,
      CH_A5,
      CH_A4,
      CH_BLEND,
      CH_DELAY,
      CH_FEEDBK,
      CH_GAIN,
      CH_SPARE
   } ch_idx_e;

   typedef enum logic [1:0] {
      PK_IDLE,
      PK_SYNC,
      PK_CH,
      PK_CSUM
   } pkt_state_e;

   typedef enum logic [1:0] {
      BY_IDLE,
      BY_START,
      BY_DATA,
      BY_STOP
   } byte_state_e;

   // Rounded clock cycles per line bit.
   function automatic int div_calc(input int fclk, input int baud);
      return (fclk + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/ctrl_tx_byte.sv
// UART 8N1 byte serializer, each bit held DIV cycles.
// Ports: data/load start a byte (also accepted in the last stop cycle for
// gapless bytes), busy, byte_done = last stop-bit cycle, tx = line.
module ctrl_tx_byte
   import ctrl_link_pkg::*;
#(
   parameter int DIV = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       load,
   output logic       busy,
   output logic       byte_done,
   output logic       tx
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   byte_state_e   state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          tx_q, tx_d;
   logic          bit_end;

   assign bit_end   = (div_q == DIV_LAST);
   assign busy      = (state_q != BY_IDLE);
   assign byte_done = (state_q == BY_STOP) && bit_end;
   assign tx        = tx_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      if (state_q != BY_IDLE) begin
         div_d = bit_end ? '0 : div_q + 1'b1;
      end
      unique case (state_q)
         BY_IDLE: begin
            tx_d = 1'b1;
            if (load) begin
               state_d = BY_START;
               sh_d    = data;
               tx_d    = 1'b0;
               div_d   = '0;
            end
         end
         BY_START: begin
            if (bit_end) begin
               state_d = BY_DATA;
               bit_d   = '0;
               tx_d    = sh_q[0];
            end
         end
         BY_DATA: begin
            if (bit_end) begin
               sh_d = sh_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = BY_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = sh_d[0];
               end
            end
         end
         BY_STOP: begin
            if (bit_end) begin
               // Chain straight into the next start bit when offered.
               if (load) begin
                  state_d = BY_START;
                  sh_d    = data;
                  tx_d    = 1'b0;
               end else begin
                  state_d = BY_IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: state_d = BY_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BY_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/ctrl_tx.sv
// Analog-controls packet transmitter: SYNC, N_CH channel bytes, CSUM.
// Ports: in_ch channel values, go/ready start handshake, done end pulse,
// CTRL_TX serial line (idles high).
module ctrl_tx
   import ctrl_link_pkg::*;
#(
   parameter int          fCLK = 50_000_000,
   parameter int          BAUD = 115_200,
   parameter int          N_CH = 8,
   parameter int          BITS = 8,
   parameter logic [7:0]  SYNC = SYNC_BYTE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_CH*BITS-1:0] in_ch,
   input  logic                 go,
   output logic                 ready,
   output logic                 done,
   output logic                 CTRL_TX
);

   localparam int DIV = div_calc(fCLK, BAUD);
   localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);

   pkt_state_e           state_q, state_d;
   logic [N_CH*BITS-1:0] shadow_q, shadow_d;
   logic [7:0]           csum_q, csum_d;
   logic [7:0]           csum_in;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 done_q, done_d;
   logic                 load;
   logic [7:0]           byte_data;
   logic                 byte_busy;
   logic                 byte_done;
   logic                 start;

   always_comb begin
      csum_in = '0;
      for (int i = 0; i < N_CH; i++) begin
         csum_in = csum_in + in_ch[i*BITS +: 8];
      end
   end

   // Ready also in the final stop cycle so a held go chains packets gaplessly.
   assign ready = ((state_q == PK_IDLE) && !byte_busy)
                || ((state_q == PK_CSUM) && byte_done);
   assign start = go && ready;
   assign done  = done_q;

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      csum_d    = csum_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      load      = 1'b0;
      byte_data = SYNC;
      unique case (state_q)
         PK_IDLE: begin
         end
         PK_SYNC: begin
            if (byte_done) begin
               load      = 1'b1;
               byte_data = shadow_q[0 +: 8];
               idx_d     = '0;
               state_d   = PK_CH;
            end
         end
         PK_CH: begin
            if (byte_done) begin
               load = 1'b1;
               if (idx_q == IDX_LAST) begin
                  byte_data = csum_q;
                  state_d   = PK_CSUM;
               end else begin
                  idx_d     = idx_q + 1'b1;
                  byte_data = shadow_q[32'(idx_d)*BITS +: 8];
               end
            end
         end
         PK_CSUM: begin
            if (byte_done) begin
               done_d  = 1'b1;
               state_d = PK_IDLE;
            end
         end
         default: state_d = PK_IDLE;
      endcase
      if (start) begin
         shadow_d  = in_ch;
         csum_d    = csum_in;
         idx_d     = '0;
         load      = 1'b1;
         byte_data = SYNC;
         state_d   = PK_SYNC;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= PK_IDLE;
         shadow_q <= '0;
         csum_q   <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         csum_q   <= csum_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
      end
   end

   ctrl_tx_byte #(
      .DIV (DIV)
   ) u_byte (
      .clk       (clk),
      .reset     (reset),
      .data      (byte_data),
      .load      (load),
      .busy      (byte_busy),
      .byte_done (byte_done),
      .tx        (CTRL_TX)
   );

endmodule

// File: tb/tb_ctrl_tx.sv
// Bench for ctrl_tx: random packets vs a byte-level model and a
// mid-bit sampling receiver, plus handshake, timing and reset cases.
module tb_ctrl_tx;
   import ctrl_link_pkg::*;

   localparam int N_CH = 8;
   localparam int DIV  = 10;
   localparam int PKT  = (N_CH + 2) * 10 * DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        go = 1'b0;
   logic [63:0] in_ch = '0;
   logic        ready;
   logic        done;
   logic        CTRL_TX;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rxq[$];
   int expq[$];
   int tq[$];
   int dq[$];
   logic tx_prev = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ctrl_tx #(
      .fCLK (1_000_000),
      .BAUD (100_000),
      .N_CH (N_CH),
      .BITS (8),
      .SYNC (8'hA5)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_ch   (in_ch),
      .go      (go),
      .ready   (ready),
      .done    (done),
      .CTRL_TX (CTRL_TX)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Line transitions and done pulses, stamped with the edge index.
   always @(negedge clk) begin
      if (CTRL_TX !== tx_prev) tq.push_back(cyc);
      tx_prev = CTRL_TX;
      if (done === 1'b1) dq.push_back(cyc);
   end

   // Receiver: find the start edge, sample each bit at mid-bit.
   initial begin : rx
      int   b;
      logic fr_ok;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0 || CTRL_TX !== 1'b0) continue;
         repeat (4) @(negedge clk);
         fr_ok = (CTRL_TX === 1'b0);
         b = 0;
         for (int j = 0; j < 8; j++) begin
            repeat (10) @(negedge clk);
            if (CTRL_TX === 1'b1) b |= (1 << j);
         end
         repeat (10) @(negedge clk);
         if (CTRL_TX !== 1'b1) fr_ok = 1'b0;
         rxq.push_back(fr_ok ? b : -1);
      end
   end

   // Expected packet: sync, channel bytes, sum of channels mod 256.
   function automatic void model_pkt(input logic [63:0] ch);
      int sum;
      int v;
      sum = 0;
      expq.push_back(int'(SYNC_BYTE));
      for (int i = 0; i < N_CH; i++) begin
         v = int'(ch[8*i +: 8]);
         expq.push_back(v);
         sum += v;
      end
      expq.push_back(sum % 256);
   endfunction

   task automatic cmp_rx(input string tag);
      chk({tag, "_nbytes"}, rxq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < rxq.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), rxq[i], expq[i]);
      rxq.delete();
      expq.delete();
   endtask

   task automatic chk_edges(input string tag, input int e0);
      int nbad;
      nbad = 0;
      foreach (tq[i]) if ((tq[i] - e0) % DIV != 0) nbad++;
      chk(tag, nbad, 0);
      tq.delete();
   endtask

   task automatic start_go(output int e);
      int n;
      n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      e = cyc;
   endtask

   task automatic wait_done(input int e, input string tag);
      int n;
      int rdy_hi;
      n = 0;
      rdy_hi = 0;
      while (done !== 1'b1 && n < PKT + 50) begin
         if (cyc - e <= PKT - 2 && ready !== 1'b0) rdy_hi++;
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_lat"}, cyc - e, PKT);
      chk({tag, "_rdy_low"}, rdy_hi, 0);
      chk({tag, "_rdy_back"}, ready, 1'b1);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, done, 1'b0);
   endtask

   task automatic run_pkt(input logic [63:0] ch, input string tag);
      int e;
      in_ch = ch;
      model_pkt(ch);
      tq.delete();
      start_go(e);
      wait_done(e, tag);
      chk_edges({tag, "_edges"}, e);
      repeat (2) @(negedge clk);
      cmp_rx(tag);
   endtask

   initial begin
      int          e;
      int          n;
      int          lows;
      logic [63:0] ch;

      repeat (3) @(negedge clk);
      chk("rst_tx", CTRL_TX, 1'b1);
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
      reset = 1'b0;
      lows = 0;
      repeat (200) begin
         @(negedge clk);
         if (CTRL_TX !== 1'b1) lows++;
      end
      chk("idle_high", lows, 0);

      run_pkt(64'h0807060504030201, "inc");
      run_pkt(64'hFFFF_FFFF_FFFF_FFFF, "ff");
      run_pkt(64'hA5A5_A5A5_A5A5_A5A5, "a5");
      for (int k = 0; k < 4; k++)
         run_pkt({$urandom, $urandom}, $sformatf("rnd%0d", k));

      // go pulses and in_ch changes while busy must not disturb the packet
      ch = {$urandom, $urandom};
      in_ch = ch;
      model_pkt(ch);
      tq.delete();
      dq.delete();
      start_go(e);
      n = 0;
      while (done !== 1'b1 && n < PKT + 50) begin
         if (cyc == e + 200) in_ch = ~ch;
         go = (cyc == e || cyc == e + 499 || cyc == e + 998);
         @(negedge clk);
         n++;
      end
      go = 1'b0;
      chk("ign_done_lat", cyc - e, PKT);
      chk_edges("ign_edges", e);
      lows = 0;
      repeat (PKT + 100) begin
         @(negedge clk);
         if (CTRL_TX !== 1'b1) lows++;
      end
      chk("ign_no_2nd", lows, 0);
      chk("ign_ndone", dq.size(), 1);
      cmp_rx("ign");

      // go held high: gapless back-to-back packets
      ch = {$urandom, $urandom};
      in_ch = ch;
      repeat (3) model_pkt(ch);
      tq.delete();
      dq.delete();
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      e = cyc;
      n = 0;
      while (dq.size() < 2 && n < 2 * PKT + 100) begin
         @(negedge clk);
         n++;
      end
      go = 1'b0;
      n = 0;
      while (dq.size() < 3 && n < PKT + 100) begin
         @(negedge clk);
         n++;
      end
      chk("held_ndone", dq.size(), 3);
      if (dq.size() == 3) begin
         chk("held_d0", dq[0] - e, PKT);
         chk("held_d1", dq[1] - dq[0], PKT);
         chk("held_d2", dq[2] - dq[1], PKT);
      end
      chk_edges("held_edges", e);
      repeat (2) @(negedge clk);
      cmp_rx("held");
      repeat (PKT + 50) @(negedge clk);
      chk("held_stop", dq.size(), 3);

      // reset in the middle of a data bit
      ch = {$urandom, $urandom};
      in_ch = ch;
      dq.delete();
      start_go(e);
      while (cyc < e + 437) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mrst_tx", CTRL_TX, 1'b1);
      chk("mrst_ready", ready, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      lows = 0;
      repeat (PKT + 200) begin
         @(negedge clk);
         if (CTRL_TX !== 1'b1) lows++;
      end
      chk("mrst_no_done", dq.size(), 0);
      chk("mrst_line_idle", lows, 0);
      rxq.delete();
      expq.delete();
      run_pkt({$urandom, $urandom}, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
